// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with valid strobe and sticky carry flag.
// Result appears one cycle after an accepted operand set; no backpressure.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
    output logic             carry,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             out_valid,
    output logic             carry_sticky,
    input  logic             sticky_clr
);
    logic [WIDTH:0]   c_chain;
    logic [WIDTH-1:0] s_comb;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic             sticky_q, sticky_d;

    assign c_chain[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c_chain[i]),
            .s_o (s_comb[i]),
            .c_o (c_chain[i+1])
        );
    end

    // Idle cycles never look at the operands, so X on them cannot leak in.
    always_comb begin
        sum_d    = sum_q;
        carry_d  = carry_q;
        valid_d  = 1'b0;
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
        if (in_valid) begin
            sum_d   = s_comb;
            carry_d = c_chain[WIDTH];
            valid_d = 1'b1;
            if (c_chain[WIDTH]) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
        end
    end

    assign sum          = sum_q;
    assign carry        = carry_q;
    assign out_valid    = valid_q;
    assign carry_sticky = sticky_q;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=4 against an arithmetic model.
// Directed vectors pin the model; random traffic is checked every cycle.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       a1, b1, cin1, iv1, clr1;
    logic [0:0] s1;
    logic       c1, ov1, st1;

    logic [3:0] a4, b4, s4;
    logic       cin4, iv4, clr4;
    logic       c4, ov4, st4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .carry(c1), .sum(s1), .a(a1), .b(b1), .cin(cin1),
        .clk(clk), .rst_n(rst_n), .in_valid(iv1),
        .out_valid(ov1), .carry_sticky(st1), .sticky_clr(clr1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .carry(c4), .sum(s4), .a(a4), .b(b4), .cin(cin4),
        .clk(clk), .rst_n(rst_n), .in_valid(iv4),
        .out_valid(ov4), .carry_sticky(st4), .sticky_clr(clr4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: last accepted sum/carry as plain integer addition.
    int m_s1, m_c1, m_v1, m_st1;
    int m_s4, m_c4, m_v4, m_st4;

    always @(posedge clk or negedge rst_n) begin
        int t;
        if (!rst_n) begin
            m_s1 = 0; m_c1 = 0; m_v1 = 0; m_st1 = 0;
            m_s4 = 0; m_c4 = 0; m_v4 = 0; m_st4 = 0;
        end else begin
            m_v1 = iv1 ? 1 : 0;
            if (iv1) begin
                t = int'(a1) + int'(b1) + int'(cin1);
                m_s1 = t % 2;
                m_c1 = t / 2;
            end
            if (iv1 && m_c1 == 1) m_st1 = 1;
            else if (clr1) m_st1 = 0;

            m_v4 = iv4 ? 1 : 0;
            if (iv4) begin
                t = int'(a4) + int'(b4) + int'(cin4);
                m_s4 = t % 16;
                m_c4 = t / 16;
            end
            if (iv4 && m_c4 == 1) m_st4 = 1;
            else if (clr4) m_st4 = 0;
        end
    end

    always @(negedge clk) begin
        chk("w1_sum", 32'(s1), 32'(m_s1));
        chk("w1_carry", 32'(c1), 32'(m_c1));
        chk("w1_valid", 32'(ov1), 32'(m_v1));
        chk("w1_sticky", 32'(st1), 32'(m_st1));
        chk("w4_sum", 32'(s4), 32'(m_s4));
        chk("w4_carry", 32'(c4), 32'(m_c4));
        chk("w4_valid", 32'(ov4), 32'(m_v4));
        chk("w4_sticky", 32'(st4), 32'(m_st4));
    end

    task automatic drv1(input logic v, input logic a, input logic b,
                        input logic c, input logic clr);
        iv1 = v; a1 = a; b1 = b; cin1 = c; clr1 = clr;
    endtask

    task automatic drv4(input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic c,
                        input logic clr);
        iv4 = v; a4 = a; b4 = b; cin4 = c; clr4 = clr;
    endtask

    logic [1:0] exp28 [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                              2'b01, 2'b10, 2'b10, 2'b11};
    logic [3:0] v30a [3] = '{4'hF, 4'h7, 4'h3};
    logic [3:0] v30b [3] = '{4'h1, 4'h8, 4'h4};
    logic       v30c [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] e30s [3] = '{4'h0, 4'h0, 4'h7};
    logic       e30c [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        logic [2:0] vec;
        drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drv4(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sum1", 32'(s1), 32'd0);
        chk("rst_carry4", 32'(c4), 32'd0);
        chk("rst_valid4", 32'(ov4), 32'd0);
        chk("rst_sticky1", 32'(st1), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_sum4", 32'(s4), 32'd0);
        rst_n = 1'b1;
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Truth-table sweep on the 1-bit instance.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("sweep", 32'({c1, s1}), 32'(exp28[i-1]));
                chk("sweep_valid", 32'(ov1), 32'd1);
            end
            vec = 3'(i);
            if (i < 8) drv1(1'b1, vec[2], vec[1], vec[0], 1'b0);
            else drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Hold after a single accepted 1+1+1, operands X while idle.
        @(negedge clk);
        drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("hold_first", 32'({ov1, c1, s1}), 32'b111);
        chk("hold_sticky", 32'(st1), 32'd1);
        drv1(1'b0, 1'bx, 1'bx, 1'bx, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_idle", 32'({ov1, c1, s1}), 32'b011);
        end

        // 4-bit directed vectors, back to back.
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("w4_dir_sum", 32'(s4), 32'(e30s[i-1]));
                chk("w4_dir_carry", 32'(c4), 32'(e30c[i-1]));
                chk("w4_dir_valid", 32'(ov4), 32'd1);
            end
            if (i < 3) drv4(1'b1, v30a[i], v30b[i], v30c[i], 1'b0);
            else drv4(1'b0, 4'hx, 4'hx, 1'bx, 1'b0);
        end
        @(negedge clk);
        chk("w4_idle_sum", 32'(s4), 32'h7);

        // Sticky set/clear priority.
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("sticky_clr0", 32'(st1), 32'd0);
        drv1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sticky_set", 32'(st1), 32'd1);
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("sticky_clr", 32'(st1), 32'd0);
        drv1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("sticky_set_wins", 32'(st1), 32'd1);
        drv1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("sticky_clr_nocarry", 32'(st1), 32'd0);

        // Random traffic; the compare process checks every cycle.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0)
                drv1(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 7) == 0);
            else
                drv1(1'b0, 1'bx, 1'bx, 1'bx, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0)
                drv4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
                     $urandom_range(0, 7) == 0);
            else
                drv4(1'b0, 4'hx, 4'hx, 1'bx, $urandom_range(0, 7) == 0);
            @(negedge clk);
        end

        // Reset pulled between edges while streaming.
        drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drv4(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_1", 32'({st1, ov1, c1, s1}), 32'd0);
        chk("midrst_4", 32'({st4, ov4, c4, s4}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv4(1'b1, 4'h1, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_1", 32'({ov1, c1, s1}), 32'b101);
        chk("post_rst_4", 32'({ov4, c4, s4}), 32'h21);
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
